lib_onehot_sched: RTL and testbench
===================================

LIB_ONEHOT_SCHED -- requirements
Module: lib_onehot_sched

Interface
REQ-001 Parameter WIDTH, default 16: width of the input vector and of each one-hot grant.
REQ-002 Parameter LSB_MSB, default 0: 0 issues grants starting from bit 0 upward; 1 issues grants starting from bit WIDTH-1 downward.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port vect_i  input  WIDTH  vector to decompose into one-hot grants.
REQ-006 Port vld_i  input  1  vect_i valid.
REQ-007 Port rdy_o  output  1  block can accept vect_i.
REQ-008 Port flush_i  input  1  synchronous abort of the vector in progress.
REQ-009 Port onehot_o  output  WIDTH  current one-hot grant.
REQ-010 Port vld_o  output  1  onehot_o valid.
REQ-011 Port rdy_i  input  1  downstream accepts onehot_o.
REQ-012 Port last_o  output  1  onehot_o is the final grant of the current vector.
REQ-013 Port idx_o  output  $clog2(WIDTH)  binary bit index of onehot_o; present only per REQ-032.

Function
REQ-014 The block SHALL use a two-state FSM: IDLE and BUSY, plus a WIDTH-bit residue register.
REQ-015 IDLE: rdy_o=1, vld_o=0, onehot_o=0, last_o=0.
REQ-016 An input transfer SHALL occur when vld_i and rdy_o are both 1 on a clock edge.
REQ-017 IDLE, transfer with vect_i!=0: load residue<=vect_i and go to BUSY.
REQ-018 IDLE, transfer with vect_i==0: the vector SHALL be consumed and dropped; state stays IDLE; no grant is issued.
REQ-019 BUSY: vld_o=1; onehot_o SHALL be the first set bit of residue, searched in the direction set by LSB_MSB, and SHALL be driven combinationally from the registered residue.
REQ-020 BUSY: last_o=1 iff residue has exactly one bit set.
REQ-021 An output transfer SHALL occur when vld_o and rdy_i are both 1; on it, residue<=residue XOR onehot_o.
REQ-022 With rdy_i=0, onehot_o, last_o, idx_o and residue SHALL hold stable.
REQ-023 Output transfer with last_o=1 and no input transfer: go to IDLE.
REQ-024 BUSY: rdy_o = last_o AND rdy_i AND NOT flush_i. The path from rdy_i to rdy_o is combinational and is permitted.
REQ-025 Output transfer with last_o=1 and an input transfer on the same edge: load the new vector per REQ-017/018 with no bubble cycle.
REQ-026 Latency: a vector accepted on edge N SHALL present its first grant after edge N; grants SHALL issue at most one per cycle; a vector with K set bits SHALL complete in K output transfers.
REQ-027 flush_i=1 on an edge SHALL clear residue to 0 and force IDLE, with priority over all other events; rdy_o=0 while flush_i=1.

Reset
REQ-028 rst=1 SHALL immediately, asynchronously, force IDLE and residue=0. Outputs: rdy_o=1, vld_o=0, onehot_o=0, last_o=0, idx_o=0.
REQ-029 Reset asserted mid-vector SHALL discard the remaining grants; none are reissued after release.
REQ-030 The first input transfer SHALL be allowed on the first edge after rst deasserts.

Configuration
REQ-031 Macro LIB_ONEHOT_SCHED_IDX_EN SHALL control whether the block includes the index encoder.
REQ-032 When LIB_ONEHOT_SCHED_IDX_EN is defined, idx_o SHALL exist and equal the bit position of onehot_o; idx_o=0 when vld_o=0.
REQ-033 When LIB_ONEHOT_SCHED_IDX_EN is undefined, idx_o and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=8)
REQ-034 LSB_MSB=0, vect_i=8'hA4, rdy_i=1 -> onehot_o 8'h04, 8'h20, 8'h80 on three consecutive cycles; last_o only with 8'h80; idx_o 2, 5, 7.
REQ-035 LSB_MSB=1, vect_i=8'hA4 -> onehot_o 8'h80, 8'h20, 8'h04; last_o with 8'h04.
REQ-036 vect_i=8'hA4, rdy_i=0 for 2 cycles after load -> onehot_o held at 8'h04 for 3 cycles; sequence then resumes unchanged.
REQ-037 vect_i=8'h00 with vld_i=1 -> accepted; vld_o stays 0; rdy_o stays 1.
REQ-038 vect_i=8'h03, then 8'h01 offered during the last beat -> onehot_o 8'h01, 8'h02, 8'h01 on consecutive cycles with no gap.
REQ-039 vect_i=8'hFF: flush_i after the 2nd grant -> next cycle IDLE, vld_o=0. Repeat with rst pulsed after the 2nd grant -> outputs at reset values immediately.

Source files
------------

// File: rtl/lib_onehot_sched.sv
// lib_onehot_sched: splits a multi-bit vector into a stream of one-hot grants.
// A loaded vector is held in a residue register, and one grant issues per
// accepted output beat. The grant order is bit 0 upward (LSB_MSB=0) or bit
// WIDTH-1 downward (LSB_MSB=1). When the final grant is accepted, a new vector
// can load on the same edge, so back-to-back vectors leave no gap.
// Optional feature: define LIB_ONEHOT_SCHED_IDX_EN to add the idx_o binary
// index output and its encoder.
module lib_onehot_sched #(
   parameter int WIDTH   = 16,
   parameter int LSB_MSB = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          vect_i,
   input  logic                      vld_i,
   output logic                      rdy_o,
   input  logic                      flush_i,
   output logic [WIDTH-1:0]          onehot_o,
   output logic                      vld_o,
   input  logic                      rdy_i,
   output logic                      last_o
`ifdef LIB_ONEHOT_SCHED_IDX_EN
   ,
   output logic [$clog2(WIDTH)-1:0]  idx_o
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] residue, residue_nxt;
   logic [WIDTH-1:0] grant;
   logic             single;
   logic             in_xfer, out_xfer;

   assign in_xfer  = vld_i & rdy_o;
   assign out_xfer = vld_o & rdy_i;

   // Detect whether the residue holds exactly one set bit; this makes the
   // grant now on offer the final grant of the vector.
   assign single = (residue != '0) && ((residue & (residue - WIDTH'(1))) == '0);

   generate
      if (LSB_MSB == 0) begin : g_lsb
         // Find the lowest set bit: two's-complement isolation of the least significant one.
         always_comb begin
            grant = residue & (~residue + WIDTH'(1));
         end
      end else begin : g_msb
         // Find the highest set bit by scanning downward; the first hit wins.
         always_comb begin
            // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
            logic found;
            grant = '0;
            found = 1'b0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
               if (residue[i] && !found) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
         end
      end
   endgenerate

   // Hold the FSM state and the residue, with asynchronous reset to IDLE and an empty residue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         residue <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
         state   <= state_nxt;
         residue <= residue_nxt;
      end
   end

   // Compute the next state and residue. Flush overrides every other event.
   always_comb begin
      state_nxt   = state;
      residue_nxt = residue;
      if (flush_i) begin
         state_nxt   = IDLE;
         residue_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               // An all-zero vector is accepted and then dropped, with no grant.
               if (in_xfer && (vect_i != '0)) begin
                  state_nxt   = BUSY;
                  residue_nxt = vect_i;
               end
            end
            BUSY: begin
               if (out_xfer) begin
                  if (last_o) begin
                     // rdy_o is high only on the final beat, so a new vector
                     // can replace the residue here without a bubble cycle.
                     if (in_xfer && (vect_i != '0)) begin
                        state_nxt   = BUSY;
                        residue_nxt = vect_i;
                     end else begin
                        state_nxt   = IDLE;
                        residue_nxt = '0;
                     end
                  end else begin
                     residue_nxt = residue ^ grant;
                  end
               end
            end
            default: begin
               state_nxt   = IDLE;
               residue_nxt = '0;
            end
         endcase
      end
   end

   // Drive the outputs from the registered state. rdy_o depends combinationally on rdy_i and flush_i.
   always_comb begin
      vld_o    = 1'b0;
      onehot_o = '0;
      last_o   = 1'b0;
      rdy_o    = 1'b0;
      if (state == BUSY) begin
         vld_o    = 1'b1;
         onehot_o = grant;
         last_o   = single;
         rdy_o    = single & rdy_i & ~flush_i;
      end else begin
         rdy_o    = ~flush_i;
      end
   end

`ifdef LIB_ONEHOT_SCHED_IDX_EN
   localparam int IDX_W = $clog2(WIDTH);

   // Encode the one-hot grant as a binary index. The index is 0 when no grant is offered.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot_o[i]) begin
            idx_o = idx_o | i[IDX_W-1:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_lib_onehot_sched.sv
// tb_lib_onehot_sched: directed bench for lib_onehot_sched with WIDTH=8.
// Two instances share every input. dut0 grants from the LSB upward and dut1
// from the MSB downward. Both vectors in each test have the same number of set
// bits, so the two instances stay in lockstep.
// Build with LIB_ONEHOT_SCHED_IDX_EN defined to also check idx_o.
module tb_lib_onehot_sched;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] vect_i = '0;
   logic         vld_i = 1'b0;
   logic         flush_i = 1'b0;
   logic         rdy_i = 1'b1;

   logic         rdy0, vld0, last0, rdy1, vld1, last1;
   logic [W-1:0] oh0, oh1;
`ifdef LIB_ONEHOT_SCHED_IDX_EN
   logic [2:0]   idx0, idx1;
`endif

   // Snapshots: dut0 {vld,last,rdy,onehot}, dut1 {vld,last,onehot}
   logic [10:0]  st0;
   logic [9:0]   st1;
   assign st0 = {vld0, last0, rdy0, oh0};
   assign st1 = {vld1, last1, oh1};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lib_onehot_sched #(.WIDTH(W), .LSB_MSB(0)) dut0 (
      .clk(clk), .rst(rst), .vect_i(vect_i), .vld_i(vld_i), .rdy_o(rdy0),
      .flush_i(flush_i), .onehot_o(oh0), .vld_o(vld0), .rdy_i(rdy_i), .last_o(last0)
`ifdef LIB_ONEHOT_SCHED_IDX_EN
      , .idx_o(idx0)
`endif
   );

   lib_onehot_sched #(.WIDTH(W), .LSB_MSB(1)) dut1 (
      .clk(clk), .rst(rst), .vect_i(vect_i), .vld_i(vld_i), .rdy_o(rdy1),
      .flush_i(flush_i), .onehot_o(oh1), .vld_o(vld1), .rdy_i(rdy_i), .last_o(last1)
`ifdef LIB_ONEHOT_SCHED_IDX_EN
      , .idx_o(idx1)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Outputs right after reset asserts, before any clock edge, and while reset is held.
   task automatic test_reset();
      rst = 1'b1;
      #2;
      total++;
      if (st0 !== 11'b001_00000000) begin
         bad++;
         $display("FAIL reset_async dut0: got %b want 00100000000", st0);
      end
      total++;
      if (st1 !== 10'b00_00000000) begin
         bad++;
         $display("FAIL reset_async dut1: got %b want 0000000000", st1);
      end
`ifdef LIB_ONEHOT_SCHED_IDX_EN
      total++;
      if (idx0 !== 3'd0) begin
         bad++;
         $display("FAIL reset_idx: got %0d want 0", idx0);
      end
`endif
      step();
      step();
      rst = 1'b0;
   endtask

   // Check LSB-first and MSB-first order on 8'hA4, with rdy_i held high.
   task automatic test_order();
      logic [7:0] e0[4], e1[4];
      logic       ev[4], el[4], er[4];
      logic [2:0] ei[4];
      e0 = '{8'h04, 8'h20, 8'h80, 8'h00};
      e1 = '{8'h80, 8'h20, 8'h04, 8'h00};
      ev = '{1, 1, 1, 0};
      el = '{0, 0, 1, 0};
      er = '{0, 0, 1, 1};
      ei = '{3'd2, 3'd5, 3'd7, 3'd0};
      rdy_i  = 1'b1;
      vect_i = 8'hA4;
      vld_i  = 1'b1;
      step();
      vld_i  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (st0 !== {ev[i], el[i], er[i], e0[i]}) begin
            bad++;
            $display("FAIL order_lsb[%0d]: got %b want %b", i, st0, {ev[i], el[i], er[i], e0[i]});
         end
         total++;
         if (st1 !== {ev[i], el[i], e1[i]}) begin
            bad++;
            $display("FAIL order_msb[%0d]: got %b want %b", i, st1, {ev[i], el[i], e1[i]});
         end
`ifdef LIB_ONEHOT_SCHED_IDX_EN
         total++;
         if (idx0 !== ei[i]) begin
            bad++;
            $display("FAIL order_idx[%0d]: got %0d want %0d", i, idx0, ei[i]);
         end
`endif
         step();
      end
   endtask

   // Hold rdy_i low for two cycles after the load. The grant must stay put, and the sequence must resume unchanged.
   task automatic test_stall();
      logic [7:0] e0[6], e1[6];
      logic       ri[6], ev[6], el[6], er[6];
      e0 = '{8'h04, 8'h04, 8'h04, 8'h20, 8'h80, 8'h00};
      e1 = '{8'h80, 8'h80, 8'h80, 8'h20, 8'h04, 8'h00};
      ri = '{0, 0, 1, 1, 1, 1};
      ev = '{1, 1, 1, 1, 1, 0};
      el = '{0, 0, 0, 0, 1, 0};
      er = '{0, 0, 0, 0, 1, 1};
      rdy_i  = 1'b0;
      vect_i = 8'hA4;
      vld_i  = 1'b1;
      step();
      vld_i  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rdy_i = ri[i];
         #1;
         total++;
         if (st0 !== {ev[i], el[i], er[i], e0[i]}) begin
            bad++;
            $display("FAIL stall_lsb[%0d]: got %b want %b", i, st0, {ev[i], el[i], er[i], e0[i]});
         end
         total++;
         if (st1 !== {ev[i], el[i], e1[i]}) begin
            bad++;
            $display("FAIL stall_msb[%0d]: got %b want %b", i, st1, {ev[i], el[i], e1[i]});
         end
         step();
      end
      rdy_i = 1'b1;
   endtask

   // Offer an all-zero vector. It is accepted, but no grant issues and the block stays ready.
   task automatic test_zero();
      rdy_i  = 1'b1;
      vect_i = 8'h00;
      vld_i  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (st0 !== 11'b001_00000000) begin
            bad++;
            $display("FAIL zero[%0d]: got %b want 00100000000", i, st0);
         end
         step();
      end
      vld_i = 1'b0;
   endtask

   // Load 8'h03, then offer 8'h01 during the final beat. The grants must run 01, 02, 01 with no gap.
   task automatic test_back_to_back();
      logic [7:0] e0[4], e1[4], vv[4];
      logic       vi[4], ev[4], el[4], er[4];
      e0 = '{8'h01, 8'h02, 8'h01, 8'h00};
      e1 = '{8'h02, 8'h01, 8'h01, 8'h00};
      vv = '{8'h00, 8'h01, 8'h00, 8'h00};
      vi = '{0, 1, 0, 0};
      ev = '{1, 1, 1, 0};
      el = '{0, 1, 1, 0};
      er = '{0, 1, 1, 1};
      rdy_i  = 1'b1;
      vect_i = 8'h03;
      vld_i  = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         vect_i = vv[i];
         vld_i  = vi[i];
         #1;
         total++;
         if (st0 !== {ev[i], el[i], er[i], e0[i]}) begin
            bad++;
            $display("FAIL b2b_lsb[%0d]: got %b want %b", i, st0, {ev[i], el[i], er[i], e0[i]});
         end
         total++;
         if (st1 !== {ev[i], el[i], e1[i]}) begin
            bad++;
            $display("FAIL b2b_msb[%0d]: got %b want %b", i, st1, {ev[i], el[i], e1[i]});
         end
         step();
      end
      vld_i = 1'b0;
   endtask

   // Assert flush after two grants of 8'hFF. An input offered alongside the flush must be refused.
   task automatic test_flush();
      logic [7:0] e0[5], e1[5];
      logic       fl[5], vi[5], ev[5], er[5];
      e0 = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00};
      e1 = '{8'h80, 8'h40, 8'h20, 8'h00, 8'h00};
      fl = '{0, 0, 1, 0, 0};
      vi = '{0, 0, 1, 0, 0};
      ev = '{1, 1, 1, 0, 0};
      er = '{0, 0, 0, 1, 1};
      rdy_i  = 1'b1;
      vect_i = 8'hFF;
      vld_i  = 1'b1;
      step();
      vect_i = 8'h10;
      for (int i = 0; i < 5; i++) begin
         flush_i = fl[i];
         vld_i   = vi[i];
         #1;
         total++;
         if (st0 !== {ev[i], 1'b0, er[i], e0[i]}) begin
            bad++;
            $display("FAIL flush_lsb[%0d]: got %b want %b", i, st0, {ev[i], 1'b0, er[i], e0[i]});
         end
         total++;
         if (st1 !== {ev[i], 1'b0, e1[i]}) begin
            bad++;
            $display("FAIL flush_msb[%0d]: got %b want %b", i, st1, {ev[i], 1'b0, e1[i]});
         end
         step();
      end
      flush_i = 1'b0;
      vld_i   = 1'b0;
   endtask

   // Assert reset mid-vector. The outputs must clear at once, no grant may reissue,
   // and the first edge after release must accept a new vector.
   task automatic test_reset_mid();
      rdy_i  = 1'b1;
      vect_i = 8'hFF;
      vld_i  = 1'b1;
      step();
      vld_i  = 1'b0;
      step();
      step();
      total++;
      if (st0 !== 11'b100_00000100) begin
         bad++;
         $display("FAIL rstmid_pre: got %b want 10000000100", st0);
      end
      #2;
      rst    = 1'b1;
      vect_i = 8'h05;
      vld_i  = 1'b1;
      #1;
      total++;
      if (st0 !== 11'b001_00000000) begin
         bad++;
         $display("FAIL rstmid_async dut0: got %b want 00100000000", st0);
      end
      total++;
      if (st1 !== 10'b00_00000000) begin
         bad++;
         $display("FAIL rstmid_async dut1: got %b want 0000000000", st1);
      end
      step();
      rst = 1'b0;
      #1;
      total++;
      if (st0 !== 11'b001_00000000) begin
         bad++;
         $display("FAIL rstmid_release: got %b want 00100000000", st0);
      end
      step();
      vld_i = 1'b0;
      total++;
      if (st0 !== 11'b100_00000001) begin
         bad++;
         $display("FAIL rstmid_first_load: got %b want 10000000001", st0);
      end
      step();
      total++;
      if (st0 !== 11'b111_00000100) begin
         bad++;
         $display("FAIL rstmid_last: got %b want 11100000100", st0);
      end
      step();
      total++;
      if (st0 !== 11'b001_00000000) begin
         bad++;
         $display("FAIL rstmid_idle: got %b want 00100000000", st0);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_order();
      test_stall();
      test_zero();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
